s2_kes_ctrl: RTL and testbench

Sequencer for the stage-2 KES engine (5-cycle RiBM core, one frame at a time) between the syndrome stage and the Chien/Forney stage. It buffers incoming syndrome sets and launches the KES core with a one-cycle kes_ena pulse. It captures the error-locator and evaluator results on kes_done and presents them downstream on a valid/ready interface. All-zero syndrome sets bypass the core, and a watchdog flags a core that never completes.

---
 rtl/rs_kes_pkg.sv | 37 +++
 rtl/rs_syn_fifo.sv | 50 +++++
 rtl/s2_kes_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_s2_kes_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_kes_pkg.sv
// Shared constants and types for the stage-2 key-equation-solver sequencer.
package rs_kes_pkg;

    localparam int unsigned SYM_W      = 8;
    localparam int unsigned NUM_SYN    = 4;
    localparam int unsigned NUM_LAMBDA = 3;
    localparam int unsigned NUM_OMEGA  = 2;

    // One syndrome set packed as {syn3, syn2, syn1, syn0}.
    localparam int unsigned BUNDLE_W = NUM_SYN * SYM_W;

    // Multiplicative identity in GF(2^8): lambda(x) = 1 for an error-free frame.
    localparam logic [SYM_W-1:0] GF_ONE = 8'h01;

    // Sequencer state encoding, one-hot.
    localparam int unsigned ST_W = 4;
    localparam logic [ST_W-1:0] StIdle   = 4'b0001;
    localparam logic [ST_W-1:0] StLaunch = 4'b0010;
    localparam logic [ST_W-1:0] StWait   = 4'b0100;
    localparam logic [ST_W-1:0] StPend   = 4'b1000;

    // One result frame as presented downstream.
    typedef struct packed {
        logic [SYM_W-1:0] lambda2;
        logic [SYM_W-1:0] lambda1;
        logic [SYM_W-1:0] lambda0;
        logic [SYM_W-1:0] omega1;
        logic [SYM_W-1:0] omega0;
        logic             err_free;
        logic             fail;
    } kes_result_t;

    function automatic logic syn_all_zero(input logic [BUNDLE_W-1:0] bundle);
        return bundle == '0;
    endfunction

endpackage

// File: rtl/rs_syn_fifo.sv
// Synchronous FIFO for syndrome sets; push and pop may coincide at any occupancy.
module rs_syn_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata   = mem_q[rptr_q[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage and pointer update; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wptr_q[AW-1:0]] <= wdata;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/s2_kes_ctrl.sv
// Stage-2 KES sequencer: buffers syndrome sets, launches the core, captures and
// forwards results, bypasses all-zero sets and times out a silent core.
module s2_kes_ctrl
    import rs_kes_pkg::*;
#(
    parameter int unsigned SYN_DEPTH   = 2,
    parameter int unsigned KES_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             syn_valid,
    output logic             syn_ready,
    input  logic [SYM_W-1:0] syn0,
    input  logic [SYM_W-1:0] syn1,
    input  logic [SYM_W-1:0] syn2,
    input  logic [SYM_W-1:0] syn3,
    output logic             kes_ena,
    output logic [SYM_W-1:0] kes_syn0,
    output logic [SYM_W-1:0] kes_syn1,
    output logic [SYM_W-1:0] kes_syn2,
    output logic [SYM_W-1:0] kes_syn3,
    input  logic             kes_done,
    input  logic [SYM_W-1:0] kes_lambda0,
    input  logic [SYM_W-1:0] kes_lambda1,
    input  logic [SYM_W-1:0] kes_lambda2,
    input  logic [SYM_W-1:0] kes_omega0,
    input  logic [SYM_W-1:0] kes_omega1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_lambda0,
    output logic [SYM_W-1:0] out_lambda1,
    output logic [SYM_W-1:0] out_lambda2,
    output logic [SYM_W-1:0] out_omega0,
    output logic [SYM_W-1:0] out_omega1,
    output logic             out_err_free,
    output logic             out_fail,
    output logic             kes_err
);

    localparam int unsigned WD_W = $clog2(KES_TIMEOUT + 1);
    // Last watchdog value seen in WAIT before the core is declared dead.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(KES_TIMEOUT - 1);

    logic [ST_W-1:0]     state_q, state_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                fail_q, fail_d;
    logic                kes_err_q, kes_err_d;
    logic                out_valid_q;
    kes_result_t         res_q, res_d;
    logic                res_wr;

    logic [BUNDLE_W-1:0] fifo_wdata;
    logic [BUNDLE_W-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                slot_free;
    logic                head_zero;
    kes_result_t         core_res;
    kes_result_t         bypass_res;
    kes_result_t         fail_res;

    assign fifo_wdata = {syn3, syn2, syn1, syn0};

    rs_syn_fifo #(
        .DEPTH (SYN_DEPTH),
        .WIDTH (BUNDLE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (syn_valid),
        .wdata (fifo_wdata),
        .pop   (res_wr),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign syn_ready = !fifo_full;
    assign {kes_syn3, kes_syn2, kes_syn1, kes_syn0} = fifo_head;
    assign kes_ena   = (state_q == StLaunch);
    assign slot_free = !out_valid_q || out_ready;
    assign head_zero = syn_all_zero(fifo_head);

    // Candidate result words for the three ways a frame can leave.
    always_comb begin
        core_res          = '0;
        core_res.lambda0  = kes_lambda0;
        core_res.lambda1  = kes_lambda1;
        core_res.lambda2  = kes_lambda2;
        core_res.omega0   = kes_omega0;
        core_res.omega1   = kes_omega1;
        bypass_res          = '0;
        bypass_res.lambda0  = GF_ONE;
        bypass_res.err_free = 1'b1;
        fail_res      = '0;
        fail_res.fail = 1'b1;
    end

    // Sequencer next state, watchdog and result-write decision.
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        fail_d    = fail_q;
        kes_err_d = kes_err_q;
        res_wr    = 1'b0;
        res_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    if (!head_zero) begin
                        state_d = StLaunch;
                    end else if (slot_free) begin
                        res_wr = 1'b1;
                        res_d  = bypass_res;
                    end
                end
            end
            StLaunch: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                wd_d = wd_q + 1'b1;
                // A completion in the same cycle as the deadline still counts.
                if (kes_done) begin
                    if (slot_free) begin
                        res_wr  = 1'b1;
                        res_d   = core_res;
                        state_d = StIdle;
                    end else begin
                        state_d = StPend;
                    end
                end else if (wd_q == WD_LAST) begin
                    kes_err_d = 1'b1;
                    fail_d    = 1'b1;
                    state_d   = StPend;
                end
            end
            StPend: begin
                // Core outputs hold after kes_done, so they are forwarded directly.
                if (slot_free) begin
                    res_wr  = 1'b1;
                    res_d   = fail_q ? fail_res : core_res;
                    fail_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wd_q      <= '0;
            fail_q    <= 1'b0;
            kes_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            fail_q    <= fail_d;
            kes_err_q <= kes_err_d;
        end
    end

    // Downstream output register with valid/ready handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (res_wr) begin
            out_valid_q <= 1'b1;
            res_q       <= res_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_lambda0  = res_q.lambda0;
    assign out_lambda1  = res_q.lambda1;
    assign out_lambda2  = res_q.lambda2;
    assign out_omega0   = res_q.omega0;
    assign out_omega1   = res_q.omega1;
    assign out_err_free = res_q.err_free;
    assign out_fail     = res_q.fail;
    assign kes_err      = kes_err_q;

endmodule

// File: tb/tb_s2_kes_ctrl.sv
// Directed bench for s2_kes_ctrl with a 5-cycle KES stub and an output scoreboard.
module tb_s2_kes_ctrl;
    import rs_kes_pkg::*;

    localparam int unsigned SYN_DEPTH   = 2;
    localparam int unsigned KES_TIMEOUT = 8;

    logic       clk;
    logic       rst;
    logic       syn_valid;
    logic       syn_ready;
    logic [7:0] syn0, syn1, syn2, syn3;
    logic       kes_ena;
    logic [7:0] kes_syn0, kes_syn1, kes_syn2, kes_syn3;
    logic       kes_done;
    logic [7:0] kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_lambda0, out_lambda1, out_lambda2, out_omega0, out_omega1;
    logic       out_err_free;
    logic       out_fail;
    logic       kes_err;

    s2_kes_ctrl #(
        .SYN_DEPTH   (SYN_DEPTH),
        .KES_TIMEOUT (KES_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .syn_valid    (syn_valid),
        .syn_ready    (syn_ready),
        .syn0         (syn0),
        .syn1         (syn1),
        .syn2         (syn2),
        .syn3         (syn3),
        .kes_ena      (kes_ena),
        .kes_syn0     (kes_syn0),
        .kes_syn1     (kes_syn1),
        .kes_syn2     (kes_syn2),
        .kes_syn3     (kes_syn3),
        .kes_done     (kes_done),
        .kes_lambda0  (kes_lambda0),
        .kes_lambda1  (kes_lambda1),
        .kes_lambda2  (kes_lambda2),
        .kes_omega0   (kes_omega0),
        .kes_omega1   (kes_omega1),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_lambda0  (out_lambda0),
        .out_lambda1  (out_lambda1),
        .out_lambda2  (out_lambda2),
        .out_omega0   (out_omega0),
        .out_omega1   (out_omega1),
        .out_err_free (out_err_free),
        .out_fail     (out_fail),
        .kes_err      (kes_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    kes_result_t sb[$];
    int          stub_cnt = 0;
    bit          stub_en = 1'b1;
    bit          force_done = 1'b0;
    bit          rand_ready = 1'b0;
    int          ena_count = 0;
    int          last_ena_cyc = -1;
    int          out_count = 0;
    int          last_out_cyc = -1;

    // Stub core: fixed XOR masks so {12,34,56,78} gives lambda {01,AB,CD}, omega {EF,11}.
    function automatic kes_result_t stub_model(input logic [7:0] a, b, c, d);
        kes_result_t r;
        r         = '0;
        r.lambda0 = 8'h01;
        r.lambda1 = a ^ 8'hB9;
        r.lambda2 = b ^ 8'hF9;
        r.omega0  = c ^ 8'hB9;
        r.omega1  = d ^ 8'h69;
        return r;
    endfunction

    function automatic kes_result_t exp_for(input logic [7:0] a, b, c, d, input bit to);
        kes_result_t r;
        r = '0;
        if (a == 8'h00 && b == 8'h00 && c == 8'h00 && d == 8'h00) begin
            r.lambda0  = 8'h01;
            r.err_free = 1'b1;
        end else if (to) begin
            r.fail = 1'b1;
        end else begin
            r = stub_model(a, b, c, d);
        end
        return r;
    endfunction

    function automatic kes_result_t out_obs();
        kes_result_t r;
        r = {out_lambda2, out_lambda1, out_lambda0, out_omega1, out_omega0, out_err_free, out_fail};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: stub and monitor act on the falling edge, inputs settle #1 after the rise.
    task automatic tick();
        kes_result_t r;
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        kes_done = force_done;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) kes_done = 1'b1;
        end
        if (kes_ena === 1'b1) begin
            ena_count++;
            last_ena_cyc = cyc;
            if (stub_en) begin
                stub_cnt = 5;
                r = stub_model(kes_syn0, kes_syn1, kes_syn2, kes_syn3);
                kes_lambda0 = r.lambda0;
                kes_lambda1 = r.lambda1;
                kes_lambda2 = r.lambda2;
                kes_omega0  = r.omega0;
                kes_omega1  = r.omega1;
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            out_count++;
            last_out_cyc = cyc;
            chk("out_has_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) chk("out_frame", 64'(out_obs()), 64'(sb.pop_front()));
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic push(input logic [7:0] a, b, c, d, input bit to, output int t);
        int n;
        n = 0;
        while (syn_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("push_ready_bound", 64'(syn_ready), 64'd1);
        syn_valid = 1'b1;
        {syn0, syn1, syn2, syn3} = {a, b, c, d};
        t = cyc;
        sb.push_back(exp_for(a, b, c, d, to));
        tick();
        syn_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t;
        int e0;
        int c0;
        rst = 1'b1;
        syn_valid = 1'b0;
        {syn0, syn1, syn2, syn3} = '0;
        kes_done = 1'b0;
        {kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1} = '0;
        out_ready = 1'b0;
        repeat (3) tick();

        // Reset state.
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_obs()), 64'd0);
        chk("rst_kes_ena", 64'(kes_ena), 64'd0);
        chk("rst_kes_err", 64'(kes_err), 64'd0);
        chk("rst_syn_ready", 64'(syn_ready), 64'd1);
        chk("rst_kes_syn", 64'({kes_syn3, kes_syn2, kes_syn1, kes_syn0}), 64'd0);
        rst = 1'b0;
        tick();

        // Bypass frame.
        out_ready = 1'b1;
        e0 = ena_count;
        push(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, t);
        repeat (3) tick();
        chk("bypass_latency", 64'(last_out_cyc), 64'(t + 2));
        chk("bypass_no_ena", 64'(ena_count), 64'(e0));
        drain("bypass_drain");

        // Launch and capture.
        e0 = ena_count;
        push(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, t);
        while (cyc <= t + 8) begin
            if (cyc >= t + 2 && cyc <= t + 7)
                chk("launch_kes_syn", 64'({kes_syn3, kes_syn2, kes_syn1, kes_syn0}),
                    64'(32'h78563412));
            tick();
        end
        chk("launch_ena_cycle", 64'(last_ena_cyc), 64'(t + 2));
        chk("launch_ena_once", 64'(ena_count), 64'(e0 + 1));
        chk("launch_out_cycle", 64'(last_out_cyc), 64'(t + 8));
        drain("launch_drain");

        // Backpressure: frame 1 held, frame 2 completes into PEND.
        out_ready = 1'b0;
        e0 = ena_count;
        push(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, t);
        repeat (10) tick();
        push(8'h55, 8'h66, 8'h77, 8'h88, 1'b0, t);
        repeat (10) tick();
        chk("bp_state_pend", 64'(dut.state_q), 64'(4'b1000));
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_two_launches", 64'(ena_count), 64'(e0 + 2));
        // Frame 2 still occupies the head, so SYN_DEPTH-1 more pushes fill the FIFO.
        for (int i = 0; i < int'(SYN_DEPTH) - 1; i++) begin
            push(8'(8'h90 + i), 8'hBC, 8'hDE, 8'hF0, 1'b0, t);
        end
        chk("bp_syn_ready_full", 64'(syn_ready), 64'd0);
        repeat (3) tick();
        chk("bp_no_third_ena", 64'(ena_count), 64'(e0 + 2));
        out_ready = 1'b1;
        drain("bp_drain");

        // Timeout: stub stays silent.
        stub_en = 1'b0;
        c0 = out_count;
        push(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, t);
        for (int n = 0; n < 40 && out_count == c0; n++) tick();
        chk("to_latency", 64'(last_out_cyc - last_ena_cyc), 64'(KES_TIMEOUT + 2));
        chk("to_kes_err", 64'(kes_err), 64'd1);
        stub_en = 1'b1;
        push(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, t);
        drain("to_drain");
        chk("to_kes_err_sticky", 64'(kes_err), 64'd1);

        // Stray kes_done in IDLE.
        c0 = out_count;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        repeat (3) tick();
        chk("stray_no_output", 64'(out_count), 64'(c0));
        chk("stray_out_valid", 64'(out_valid), 64'd0);
        chk("stray_state_idle", 64'(dut.state_q), 64'(4'b0001));

        // Reset during WAIT with a held output frame.
        out_ready = 1'b0;
        push(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, t);
        push(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0, t);
        repeat (3) tick();
        chk("rstw_state_wait", 64'(dut.state_q), 64'(4'b0100));
        rst = 1'b1;
        tick();
        chk("rstw_out_valid", 64'(out_valid), 64'd0);
        chk("rstw_out_data", 64'(out_obs()), 64'd0);
        chk("rstw_kes_ena", 64'(kes_ena), 64'd0);
        chk("rstw_kes_err", 64'(kes_err), 64'd0);
        chk("rstw_syn_ready", 64'(syn_ready), 64'd1);
        chk("rstw_fifo_empty", 64'(dut.u_fifo.empty), 64'd1);
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        c0 = out_count;
        repeat (8) tick();
        chk("rstw_stale_done", 64'(out_count), 64'(c0));
        chk("rstw_stale_valid", 64'(out_valid), 64'd0);

        // Mixed stream under random backpressure.
        rand_ready = 1'b1;
        c0 = out_count;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, t);
            else push(8'(16 * i + 1), 8'(i), 8'h5A, 8'(8'hC0 + i), 1'b0, t);
            repeat (int'($urandom_range(0, 3))) tick();
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain("mix_drain");
        repeat (3) tick();
        chk("mix_count", 64'(out_count - c0), 64'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
